// File: rtl/alu_ctrl_muldiv.sv
// alu_ctrl_muldiv: ALU control decoder plus an iterative multiply/divide unit
// that owns the HI/LO register pair.
//   - Decode: alu_op/funct -> 4-bit alu_control and illegal. Purely combinational.
//   - Mul/div: one bit per cycle, WIDTH cycles from the start edge to the HI/LO write.
//   - Stall: a HI/LO-class instruction arriving while the unit is busy is held.
//     Every other instruction proceeds while the unit is busy.
// Ports:
//   Inputs:  clk, rst_n (async, active-low), valid, alu_op[1:0], funct[5:0],
//            rs_val, rt_val
//   Outputs: alu_control[3:0], illegal, busy (registered), stall,
//            hilo_data (HI for MFHI, LO for MFLO, otherwise 0)
module alu_ctrl_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             valid,
  input  logic [1:0]       alu_op,
  input  logic [5:0]       funct,
  input  logic [WIDTH-1:0] rs_val,
  input  logic [WIDTH-1:0] rt_val,
  output logic [3:0]       alu_control,
  output logic             illegal,
  output logic             busy,
  output logic             stall,
  output logic [WIDTH-1:0] hilo_data
);

  localparam int CW = $clog2(WIDTH);

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2
  } state_e;

  // ---------------------------------------------------------------------------
  // Decode
  // ---------------------------------------------------------------------------
  logic funct_known;
  logic is_hilo;
  logic is_mul;
  logic is_div;
  logic is_mfhi;
  logic is_mflo;
  logic is_mthi;
  logic is_mtlo;

  always_comb begin
    alu_control = 4'b1111;
    funct_known = 1'b0;
    is_hilo     = 1'b0;
    is_mul      = 1'b0;
    is_div      = 1'b0;
    is_mfhi     = 1'b0;
    is_mflo     = 1'b0;
    is_mthi     = 1'b0;
    is_mtlo     = 1'b0;
    case (alu_op)
      2'b00: alu_control = 4'b0010;
      2'b01: alu_control = 4'b0110;
      2'b11: alu_control = 4'b0001;
      default: begin
        funct_known = 1'b1;
        case (funct)
          F_ADD:  alu_control = 4'b0010;
          F_SUB:  alu_control = 4'b0110;
          F_AND:  alu_control = 4'b0000;
          F_OR:   alu_control = 4'b0001;
          F_NOR:  alu_control = 4'b1100;
          F_SLT:  alu_control = 4'b0111;
          F_MULT, F_MULTU: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_mul      = 1'b1;
          end
          F_DIV, F_DIVU: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_div      = 1'b1;
          end
          F_MFHI: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_mfhi     = 1'b1;
          end
          F_MFLO: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_mflo     = 1'b1;
          end
          F_MTHI: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_mthi     = 1'b1;
          end
          F_MTLO: begin
            alu_control = 4'b0000;
            is_hilo     = 1'b1;
            is_mtlo     = 1'b1;
          end
          default: begin
            alu_control = 4'b1111;
            funct_known = 1'b0;
          end
        endcase
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_e             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  // Shared working register.
  //   MUL: {partial product high half, multiplier shifting out at bit 0}
  //   DIV: {remainder, dividend shifting out at the top / quotient shifting in}
  logic [2*WIDTH-1:0] prod_q, prod_d;
  logic [WIDTH-1:0]   opb_q, opb_d;     // multiplicand or divisor magnitude
  logic               neg_q, neg_d;     // product / quotient needs negation
  logic               rneg_q, rneg_d;   // remainder takes the dividend's sign
  logic               dz_q, dz_d;       // divisor was zero at the start edge
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  assign busy      = (state_q != S_IDLE);
  assign stall     = valid & busy & is_hilo;
  assign illegal   = valid & (alu_op == 2'b10) & ~funct_known;
  assign hilo_data = (valid & is_mfhi) ? hi_q :
                     (valid & is_mflo) ? lo_q : '0;

  logic accept;
  assign accept = valid & ~stall;

  // Signed variants have funct[0] == 0 (MULT, DIV); unsigned have funct[0] == 1.
  logic             signed_op;
  logic             rs_neg;
  logic             rt_neg;
  logic [WIDTH-1:0] rs_mag;
  logic [WIDTH-1:0] rt_mag;

  assign signed_op = ~funct[0];
  assign rs_neg    = signed_op & rs_val[WIDTH-1];
  assign rt_neg    = signed_op & rt_val[WIDTH-1];
  assign rs_mag    = rs_neg ? (~rs_val + 1'b1) : rs_val;
  assign rt_mag    = rt_neg ? (~rt_val + 1'b1) : rt_val;

  logic last_iter;
  assign last_iter = (cnt_q == CW'(WIDTH - 1));

  // Shift-add step: conditionally add the multiplicand into the upper half,
  // then shift the whole product right by one (the carry enters at the top).
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [2*WIDTH-1:0] mul_fix;

  assign mul_sum  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, opb_q} : '0);
  assign mul_next = {mul_sum, prod_q[WIDTH-1:1]};
  assign mul_fix  = neg_q ? (~mul_next + 1'b1) : mul_next;

  // Restoring step: shift the next dividend bit into the remainder, subtract
  // the divisor, keep the difference only when it did not go negative.
  // The partial remainder is always below the divisor, so the WIDTH+1 bit
  // difference cannot wrap when the subtraction succeeds.
  logic [WIDTH:0]   div_shift;
  logic [WIDTH:0]   div_trial;
  logic             div_ge;
  logic [WIDTH-1:0] div_rem_n;
  logic [WIDTH-1:0] div_quo_n;
  logic [WIDTH-1:0] div_rem_fix;
  logic [WIDTH-1:0] div_quo_fix;

  assign div_shift   = {prod_q[2*WIDTH-1:WIDTH], prod_q[WIDTH-1]};
  assign div_trial   = div_shift - {1'b0, opb_q};
  assign div_ge      = ~div_trial[WIDTH];
  assign div_rem_n   = div_ge ? div_trial[WIDTH-1:0] : div_shift[WIDTH-1:0];
  assign div_quo_n   = {prod_q[WIDTH-2:0], div_ge};
  // With a zero divisor the remainder ends up as the dividend magnitude, so
  // re-applying the dividend sign restores rs_val exactly as latched.
  assign div_rem_fix = rneg_q ? (~div_rem_n + 1'b1) : div_rem_n;
  assign div_quo_fix = dz_q ? '1 : (neg_q ? (~div_quo_n + 1'b1) : div_quo_n);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prod_d  = prod_q;
    opb_d   = opb_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (accept && (is_mul || is_div)) begin
          state_d = is_mul ? S_MUL : S_DIV;
          cnt_d   = '0;
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dz_d    = (rt_val == '0);
          if (is_mul) begin
            prod_d = {{WIDTH{1'b0}}, rt_mag};
            opb_d  = rs_mag;
          end else begin
            prod_d = {{WIDTH{1'b0}}, rs_mag};
            opb_d  = rt_mag;
          end
        end else if (accept && is_mthi) begin
          hi_d = rs_val;
        end else if (accept && is_mtlo) begin
          lo_d = rs_val;
        end
      end
      S_MUL: begin
        prod_d = mul_next;
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = mul_fix[2*WIDTH-1:WIDTH];
          lo_d    = mul_fix[WIDTH-1:0];
        end
      end
      S_DIV: begin
        prod_d = {div_rem_n, div_quo_n};
        cnt_d  = cnt_q + CW'(1);
        if (last_iter) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          hi_d    = div_rem_fix;
          lo_d    = div_quo_fix;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      prod_q  <= '0;
      opb_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prod_q  <= prod_d;
      opb_q   <= opb_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

endmodule

// File: tb/tb_alu_ctrl_muldiv.sv
// tb_alu_ctrl_muldiv: directed cases plus randomized instruction stream for
// alu_ctrl_muldiv, checked every cycle against a countdown/arithmetic model.
module tb_alu_ctrl_muldiv;

  localparam int W = 32;

  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_NOR   = 6'b100111;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         valid;
  logic [1:0]   alu_op;
  logic [5:0]   funct;
  logic [W-1:0] rs_val;
  logic [W-1:0] rt_val;
  logic [3:0]   alu_control;
  logic         illegal;
  logic         busy;
  logic         stall;
  logic [W-1:0] hilo_data;

  alu_ctrl_muldiv #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .valid       (valid),
    .alu_op      (alu_op),
    .funct       (funct),
    .rs_val      (rs_val),
    .rt_val      (rt_val),
    .alu_control (alu_control),
    .illegal     (illegal),
    .busy        (busy),
    .stall       (stall),
    .hilo_data   (hilo_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: HI/LO, a countdown of remaining busy cycles, and the
  // result that lands when the countdown reaches zero.
  logic [W-1:0] m_hi, m_lo;
  int           m_cnt;
  logic [63:0]  m_pend;

  logic [W-1:0] last_hilo;
  logic         last_stall;
  logic [3:0]   last_ctrl;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic is_hilo_fn(input logic [5:0] fn);
    return fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU, F_MFHI, F_MFLO, F_MTHI, F_MTLO};
  endfunction

  function automatic logic [3:0] exp_ctrl(input logic [1:0] op, input logic [5:0] fn);
    if (op == 2'b00) return 4'b0010;
    if (op == 2'b01) return 4'b0110;
    if (op == 2'b11) return 4'b0001;
    case (fn)
      F_ADD: return 4'b0010;
      F_SUB: return 4'b0110;
      F_AND: return 4'b0000;
      F_OR:  return 4'b0001;
      F_NOR: return 4'b1100;
      F_SLT: return 4'b0111;
      default: return is_hilo_fn(fn) ? 4'b0000 : 4'b1111;
    endcase
  endfunction

  function automatic logic exp_known(input logic [5:0] fn);
    return is_hilo_fn(fn) || (fn inside {F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT});
  endfunction

  // {HI, LO} from plain arithmetic.
  function automatic logic [63:0] ref_res(input logic [5:0] fn, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
    longint sp;
    logic [63:0] up;
    int sa, sb, q, r;
    case (fn)
      F_MULT: begin
        sp = longint'($signed(a)) * longint'($signed(b));
        return 64'(sp);
      end
      F_MULTU: begin
        up = {32'd0, a} * {32'd0, b};
        return up;
      end
      F_DIV: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        sa = $signed(a);
        sb = $signed(b);
        q  = sa / sb;
        r  = sa % sb;
        return {32'(r), 32'(q)};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // One clock cycle: drive, check combinational and registered outputs
  // against the model before the edge, then advance the model at the edge.
  task automatic cyc(input logic v, input logic [1:0] op, input logic [5:0] fn,
                     input logic [W-1:0] a, input logic [W-1:0] b);
    logic hl, es, acc;
    logic [W-1:0] eh;
    valid  = v;
    alu_op = op;
    funct  = fn;
    rs_val = a;
    rt_val = b;
    #3;
    hl  = (op == 2'b10) && is_hilo_fn(fn);
    es  = v && (m_cnt > 0) && hl;
    acc = v && !es;
    eh  = (v && op == 2'b10 && fn == F_MFHI) ? m_hi :
          (v && op == 2'b10 && fn == F_MFLO) ? m_lo : '0;
    check_eq("alu_control", 64'(alu_control), 64'(exp_ctrl(op, fn)));
    check_eq("illegal", 64'(illegal), 64'(v && op == 2'b10 && !exp_known(fn)));
    check_eq("stall", 64'(stall), 64'(es));
    check_eq("busy", 64'(busy), 64'(m_cnt > 0));
    check_eq("hilo_data", 64'(hilo_data), 64'(eh));
    last_hilo  = hilo_data;
    last_stall = stall;
    last_ctrl  = alu_control;
    @(posedge clk);
    if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) {m_hi, m_lo} = m_pend;
    end else if (acc && op == 2'b10 && (fn inside {F_MULT, F_MULTU, F_DIV, F_DIVU})) begin
      m_cnt  = W;
      m_pend = ref_res(fn, a, b);
    end else if (acc && op == 2'b10 && fn == F_MTHI) begin
      m_hi = a;
    end else if (acc && op == 2'b10 && fn == F_MTLO) begin
      m_lo = a;
    end
    #1;
  endtask

  task automatic nop();
    cyc(1'b0, 2'b00, 6'd0, $urandom, $urandom);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && (m_cnt > 0 || busy); i++) nop();
    check_eq("idle_timeout", 64'(busy), 64'(0));
  endtask

  task automatic op_then_read(input logic [5:0] fn, input logic [W-1:0] a, input logic [W-1:0] b,
                              input string tag, input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo);
    wait_idle();
    cyc(1'b1, 2'b10, fn, a, b);
    wait_idle();
    cyc(1'b1, 2'b10, F_MFHI, $urandom, $urandom);
    check_eq({tag, "_hi"}, 64'(last_hilo), 64'(exp_hi));
    cyc(1'b1, 2'b10, F_MFLO, $urandom, $urandom);
    check_eq({tag, "_lo"}, 64'(last_hilo), 64'(exp_lo));
  endtask

  function automatic logic [W-1:0] rand_operand();
    int s;
    s = $urandom_range(0, 9);
    case (s)
      0: return '0;
      1: return '1;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] fn_tab [14];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    logic [5:0] rf;
    fn_tab = '{F_ADD, F_SUB, F_AND, F_OR, F_NOR, F_SLT, F_MULT, F_MULTU,
               F_DIV, F_DIVU, F_MFHI, F_MTHI, F_MFLO, F_MTLO};
    m_hi = '0; m_lo = '0; m_cnt = 0; m_pend = '0;
    last_hilo = '0; last_stall = 1'b0; last_ctrl = '0;

    // Reset state, observed while reset is held.
    rst_n  = 1'b0;
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MFHI;
    rs_val = 32'hDEAD_BEEF;
    rt_val = 32'h1234_5678;
    #12;
    check_eq("rst_busy", 64'(busy), 64'(0));
    check_eq("rst_stall", 64'(stall), 64'(0));
    check_eq("rst_illegal", 64'(illegal), 64'(0));
    check_eq("rst_hilo", 64'(hilo_data), 64'(0));
    check_eq("rst_ctrl", 64'(alu_control), 64'(4'b0000));
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Decode table.
    for (int i = 0; i < 6; i++) cyc(1'b1, 2'b10, fn_tab[i], $urandom, $urandom);
    cyc(1'b1, 2'b00, 6'h3F, $urandom, $urandom);
    cyc(1'b1, 2'b01, 6'h3F, $urandom, $urandom);
    cyc(1'b1, 2'b11, 6'h3F, $urandom, $urandom);
    cyc(1'b1, 2'b10, 6'h3F, $urandom, $urandom);
    check_eq("illegal_ctrl", 64'(last_ctrl), 64'(4'b1111));

    // MULT -3*7 with MFLO issued one cycle after the start cycle.
    cyc(1'b1, 2'b10, F_MULT, 32'hFFFF_FFFD, 32'd7);
    nop();
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 2'b10, F_MFLO, $urandom, $urandom);
      if (!last_stall) break;
      n++;
    end
    check_eq("mflo_stall_cycles", 64'(n), 64'(31));
    check_eq("mult_lo", 64'(last_hilo), 64'(32'hFFFF_FFEB));
    cyc(1'b1, 2'b10, F_MFHI, $urandom, $urandom);
    check_eq("mult_hi", 64'(last_hilo), 64'(32'hFFFF_FFFF));

    // MULTU with an ADD proceeding during busy.
    cyc(1'b1, 2'b10, F_MULTU, 32'hFFFF_FFFD, 32'd7);
    cyc(1'b1, 2'b10, F_ADD, $urandom, $urandom);
    check_eq("add_busy_stall", 64'(last_stall), 64'(0));
    check_eq("add_busy_ctrl", 64'(last_ctrl), 64'(4'b0010));
    wait_idle();
    cyc(1'b1, 2'b10, F_MFHI, $urandom, $urandom);
    check_eq("multu_hi", 64'(last_hilo), 64'(32'h0000_0006));
    cyc(1'b1, 2'b10, F_MFLO, $urandom, $urandom);
    check_eq("multu_lo", 64'(last_hilo), 64'(32'hFFFF_FFEB));

    // Division corners.
    op_then_read(F_DIV,  32'hFFFF_FFF9, 32'd2,        "div_m7_2",  32'hFFFF_FFFF, 32'hFFFF_FFFD);
    op_then_read(F_DIVU, 32'd7,         32'd0,        "divu_z",    32'd7,         32'hFFFF_FFFF);
    op_then_read(F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, "div_ovf",  32'd0,         32'h8000_0000);
    op_then_read(F_DIV,  32'hFFFF_FFFB, 32'd0,        "div_z_neg", 32'hFFFF_FFFB, 32'hFFFF_FFFF);

    // MTHI then MFHI.
    cyc(1'b1, 2'b10, F_MTHI, 32'h1234_5678, $urandom);
    cyc(1'b1, 2'b10, F_MFHI, $urandom, $urandom);
    check_eq("mthi", 64'(last_hilo), 64'(32'h1234_5678));

    // MTLO during busy waits, then lands after the MULT result.
    cyc(1'b1, 2'b10, F_MULT, 32'd2, 32'd3);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 2'b10, F_MTLO, 32'h0000_AAAA, $urandom);
      if (!last_stall) break;
      n++;
    end
    check_eq("mtlo_stall_cycles", 64'(n), 64'(32));
    cyc(1'b1, 2'b10, F_MFLO, $urandom, $urandom);
    check_eq("mtlo_after_busy", 64'(last_hilo), 64'(32'h0000_AAAA));

    // Reset during iteration 10 of a DIV.
    cyc(1'b1, 2'b10, F_DIV, 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) nop();
    valid  = 1'b1;
    alu_op = 2'b10;
    funct  = F_MFHI;
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("midrst_busy", 64'(busy), 64'(0));
    check_eq("midrst_hi", 64'(hilo_data), 64'(0));
    funct = F_MFLO;
    #1;
    check_eq("midrst_lo", 64'(hilo_data), 64'(0));
    m_cnt = 0; m_hi = '0; m_lo = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    op_then_read(F_MULT, 32'd5, 32'd6, "post_rst_mult", 32'd0, 32'd30);

    // Randomized instruction stream.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0) rf = 6'($urandom);
      else rf = fn_tab[$urandom_range(0, 13)];
      cyc(($urandom_range(0, 4) != 0), ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b10,
          rf, rand_operand(), rand_operand());
    end
    wait_idle();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
